// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC -> imem req/gnt/rvalid -> {pc, instr} FIFO -> decode.
// Optional performance counters are enabled with `define IFETCH_PERF_CNT_EN.
module ifetch_unit #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_i,
    input  logic         flush_i,
    output logic         imem_req_o,
    output logic [N-1:0] imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [N-1:0] imem_rdata_i,
    output logic         id_valid_o,
    input  logic         id_ready_i,
    output logic [N-1:0] id_instr_o,
    output logic [N-1:0] id_pc_o,
    output logic [N-1:0] id_pc4_o,
    output logic         bubble_o
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]  stall_cnt_o,
    output logic [31:0]  fetch_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        REQ,
        WAIT_RESP,
        DRAIN
    } state_t;

    state_t         state;
    logic [N-1:0]   pc_q    [DEPTH];
    logic [N-1:0]   instr_q [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [CW-1:0]  count;
    logic [N-1:0]   inflight_pc;
    logic           full;
    logic           accept;
    logic           push;
    logic           pop;

    assign full        = (count == CW'(DEPTH));
    assign imem_req_o  = (state == REQ) & ~full & ~flush_i & ~reset;
    assign imem_addr_o = pc_i;
    assign accept      = imem_req_o & imem_gnt_i;
    assign bubble_o    = reset | (~accept & ~flush_i);

    // A response arriving together with a flush belongs to the old path.
    assign push = (state == WAIT_RESP) & imem_rvalid_i & ~flush_i;
    assign pop  = id_valid_o & id_ready_i;

    assign id_valid_o = (count != '0);
    assign id_instr_o = id_valid_o ? instr_q[head] : N'(32'h0000_0013);
    assign id_pc_o    = id_valid_o ? pc_q[head] : '0;
    assign id_pc4_o   = id_pc_o + N'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            inflight_pc <= '0;
        end else begin
            unique case (state)
                REQ: begin
                    if (accept) begin
                        inflight_pc <= pc_i;
                        state       <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (imem_rvalid_i) begin
                        state <= REQ;
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid_i) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase

            if (flush_i) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push) begin
                    tail <= tail + AW'(1);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail]    <= inflight_pc;
            instr_q[tail] <= imem_rdata_i;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_o <= '0;
            fetch_cnt_o <= '0;
        end else begin
            if (id_ready_i & ~id_valid_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (push) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit.
// Rows are applied one per cycle; multi-cycle corners follow as hand sequences.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic        bubble_o;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] fetch_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    ifetch_unit #(.N(32), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .bubble_o      (bubble_o)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .fetch_cnt_o   (fetch_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        fl;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic        bub;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] idpc;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input logic rst, input logic [31:0] pc, input logic fl,
        input logic gnt, input logic rv, input logic [31:0] rdata,
        input logic rdy, input logic req, input logic bub,
        input logic vld, input logic [31:0] instr,
        input logic [31:0] idpc, input logic [31:0] pc4
    );
        vec_t v;
        v.rst = rst; v.pc = pc; v.fl = fl; v.gnt = gnt; v.rv = rv;
        v.rdata = rdata; v.rdy = rdy; v.req = req; v.bub = bub;
        v.vld = vld; v.instr = instr; v.idpc = idpc; v.pc4 = pc4;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        pc_i          = v.pc;
        flush_i       = v.fl;
        imem_gnt_i    = v.gnt;
        imem_rvalid_i = v.rv;
        imem_rdata_i  = v.rdata;
        id_ready_i    = v.rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // rst pc fl gnt rv rdata rdy | req bub vld instr idpc pc4
        add(1, 32'h0040_0000, 0, 1, 0, 32'h0, 1, 0, 1, 0, NOP, 0, 4);
        add(1, 32'h0040_0000, 0, 1, 1, 32'hDEAD_0000, 1, 0, 1, 0, NOP, 0, 4);
        add(0, 32'h0040_0000, 0, 1, 1, 32'hDEAD_0001, 1, 1, 0, 0, NOP, 0, 4);
        add(0, 32'h0040_0004, 0, 1, 1, 32'hAAAA_0001, 1, 0, 1, 0, NOP, 0, 4);
        add(0, 32'h0040_0004, 0, 0, 0, 32'h0, 1, 1, 1, 1,
            32'hAAAA_0001, 32'h0040_0000, 32'h0040_0004);
        add(0, 32'h0040_0004, 0, 0, 0, 32'h0, 1, 1, 1, 0, NOP, 0, 4);
        add(0, 32'h0040_0004, 0, 0, 0, 32'h0, 1, 1, 1, 0, NOP, 0, 4);
        add(0, 32'h0040_0004, 0, 1, 0, 32'h0, 1, 1, 0, 0, NOP, 0, 4);
        add(0, 32'h0040_0008, 0, 0, 1, 32'hBBBB_0002, 1, 0, 1, 0, NOP, 0, 4);
        add(0, 32'h0040_0008, 0, 1, 0, 32'h0, 0, 1, 0, 1,
            32'hBBBB_0002, 32'h0040_0004, 32'h0040_0008);
        add(0, 32'h0040_000C, 0, 1, 1, 32'hCCCC_0003, 0, 0, 1, 1,
            32'hBBBB_0002, 32'h0040_0004, 32'h0040_0008);
        add(0, 32'h0040_000C, 0, 1, 1, 32'hDEAD_0002, 0, 0, 1, 1,
            32'hBBBB_0002, 32'h0040_0004, 32'h0040_0008);
        add(0, 32'h0040_000C, 0, 1, 0, 32'h0, 1, 0, 1, 1,
            32'hBBBB_0002, 32'h0040_0004, 32'h0040_0008);
        add(0, 32'h0040_000C, 0, 1, 0, 32'h0, 1, 1, 0, 1,
            32'hCCCC_0003, 32'h0040_0008, 32'h0040_000C);
        add(0, 32'h0040_0010, 1, 0, 0, 32'h0, 1, 0, 0, 0, NOP, 0, 4);
        add(0, 32'h0040_0100, 0, 1, 0, 32'h0, 1, 0, 1, 0, NOP, 0, 4);
        add(0, 32'h0040_0100, 0, 1, 1, 32'hEEEE_0005, 1, 0, 1, 0, NOP, 0, 4);
        add(0, 32'h0040_0100, 0, 1, 0, 32'h0, 1, 1, 0, 0, NOP, 0, 4);
        add(0, 32'h0040_0104, 0, 0, 1, 32'h1111_0006, 0, 0, 1, 0, NOP, 0, 4);
        add(0, 32'h0040_0104, 0, 1, 0, 32'h0, 0, 1, 0, 1,
            32'h1111_0006, 32'h0040_0100, 32'h0040_0104);
        add(0, 32'h0040_0108, 0, 0, 1, 32'h2222_0007, 0, 0, 1, 1,
            32'h1111_0006, 32'h0040_0100, 32'h0040_0104);
        add(0, 32'h0040_0108, 1, 1, 0, 32'h0, 1, 0, 0, 1,
            32'h1111_0006, 32'h0040_0100, 32'h0040_0104);
        add(0, 32'h0040_0300, 0, 1, 0, 32'h0, 1, 1, 0, 0, NOP, 0, 4);
        add(0, 32'h0040_0304, 1, 1, 1, 32'h3333_0008, 1, 0, 0, 0, NOP, 0, 4);
        add(0, 32'hFFFF_FFFC, 0, 1, 0, 32'h0, 1, 1, 0, 0, NOP, 0, 4);
        add(0, 32'h0000_0000, 0, 0, 1, 32'h4444_0009, 0, 0, 1, 0, NOP, 0, 4);
        add(0, 32'h0000_0000, 0, 0, 0, 32'h0, 0, 1, 1, 1,
            32'h4444_0009, 32'hFFFF_FFFC, 32'h0000_0000);
        add(0, 32'h0000_0000, 0, 0, 0, 32'h0, 1, 1, 1, 1,
            32'h4444_0009, 32'hFFFF_FFFC, 32'h0000_0000);
        add(0, 32'h0000_0000, 0, 0, 0, 32'h0, 1, 1, 1, 0, NOP, 0, 4);
        add(1, 32'h0000_0000, 0, 1, 0, 32'h0, 1, 0, 1, 0, NOP, 0, 4);

        drive(tbl[0]);
        @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("r%0d req", i), 32'(imem_req_o), 32'(tbl[i].req));
            chk($sformatf("r%0d bubble", i), 32'(bubble_o), 32'(tbl[i].bub));
            chk($sformatf("r%0d valid", i), 32'(id_valid_o), 32'(tbl[i].vld));
            chk($sformatf("r%0d instr", i), id_instr_o, tbl[i].instr);
            chk($sformatf("r%0d id_pc", i), id_pc_o, tbl[i].idpc);
            chk($sformatf("r%0d id_pc4", i), id_pc4_o, tbl[i].pc4);
            chk($sformatf("r%0d addr", i), imem_addr_o, tbl[i].pc);
`ifdef IFETCH_PERF_CNT_EN
            if (i == tbl.size() - 1) begin
                chk("fetch_cnt_total", fetch_cnt_o, 32'd6);
            end
`endif
        end

        // Minimum latency: grant at T, rvalid at T+1, valid at T+2.
        @(negedge clk);
        reset = 0; flush_i = 0; id_ready_i = 0;
        pc_i = 32'h0050_0000; imem_gnt_i = 1; imem_rvalid_i = 0;
        #1;
        chk("lat grant bubble", 32'(bubble_o), 32'd0);
        @(negedge clk);
        pc_i = 32'h0050_0004; imem_gnt_i = 0;
        imem_rvalid_i = 1; imem_rdata_i = 32'h5555_0010;
        @(negedge clk);
        imem_rvalid_i = 0;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            lat++;
            if (id_valid_o) break;
            @(negedge clk);
        end
        chk("lat valid", 32'(id_valid_o), 32'd1);
        chk("lat cycles", 32'(lat), 32'd1);
        chk("lat pc", id_pc_o, 32'h0050_0000);
        chk("lat instr", id_instr_o, 32'h5555_0010);

        // Reset clears buffered entries and counters.
        @(negedge clk);
        reset = 1; id_ready_i = 1; imem_gnt_i = 0;
        @(negedge clk);
        #1;
        chk("rst valid", 32'(id_valid_o), 32'd0);
        chk("rst req", 32'(imem_req_o), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst stall_cnt", stall_cnt_o, 32'd0);
        chk("rst fetch_cnt", fetch_cnt_o, 32'd0);
`endif
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
        end
        #1;
        chk("idle valid", 32'(id_valid_o), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("stall_cnt 4", stall_cnt_o, 32'd4);
        chk("fetch_cnt 0", fetch_cnt_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
